pipelined_barrel_shifter: RTL

- Parametrised, pipelined successor to the CPU's combinational barrel shifter, for the multi-cycle/pipelined datapath.
- Performs logical-left, logical-right, arithmetic-right, rotate-right and rotate-left.
- Uses a log2(DATA_WIDTH)-stage shift network with one register per stage and a valid/ready handshake at both ends, so the ALU or EX stage can stall it.
- Provides a synchronous flush for branch/exception squash.

---
 rtl/shifter_pkg.sv | 21 ++
 rtl/pipelined_barrel_shifter_if.sv | 29 ++
 rtl/pipelined_barrel_shifter_shift_stage.sv | 34 +++
 rtl/pipelined_barrel_shifter.sv | 116 +++++++++++
 4 files changed

// File: rtl/shifter_pkg.sv
// Shared op-code encoding and helpers for the pipelined barrel shifter.
package shifter_pkg;

    localparam int OP_W = 3;

    localparam logic [OP_W-1:0] OP_SLL = 3'd0;
    localparam logic [OP_W-1:0] OP_SRL = 3'd1;
    localparam logic [OP_W-1:0] OP_SRA = 3'd2;
    localparam logic [OP_W-1:0] OP_ROR = 3'd3;
    localparam logic [OP_W-1:0] OP_ROL = 3'd4;

    function automatic logic op_is_legal(input logic [OP_W-1:0] op);
        logic legal;
        case (op)
            OP_SLL, OP_SRL, OP_SRA, OP_ROR, OP_ROL: legal = 1'b1;
            default:                                legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/pipelined_barrel_shifter_if.sv
// Request/response handshake bundle between the EX stage and the shifter.
interface pipelined_barrel_shifter_if
    import shifter_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) ();

    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] data_in;
    logic [ADDR_WIDTH-1:0] shift_count;
    logic [OP_W-1:0]       op;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  out_err;

    modport master (
        output in_valid, data_in, shift_count, op, out_ready,
        input  in_ready, out_valid, data_out, out_err
    );

    modport slave (
        input  in_valid, data_in, shift_count, op, out_ready,
        output in_ready, out_valid, data_out, out_err
    );

endinterface

// File: rtl/pipelined_barrel_shifter_shift_stage.sv
// One combinational layer of the shift network: moves data by 2**STAGE when enabled.
module shift_stage
    import shifter_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int STAGE      = 0
) (
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic [OP_W-1:0]       op_i,
    input  logic                  sign_i,
    input  logic                  en_i,
    output logic [DATA_WIDTH-1:0] data_o
);

    localparam int SH = 1 << STAGE;

    // Per-op shift/rotate selection; illegal ops pass data through.
    always_comb begin
        data_o = data_i;
        if (en_i) begin
            case (op_i)
                OP_SLL:  data_o = {data_i[DATA_WIDTH-SH-1:0], {SH{1'b0}}};
                OP_SRL:  data_o = {{SH{1'b0}}, data_i[DATA_WIDTH-1:SH]};
                OP_SRA:  data_o = {{SH{sign_i}}, data_i[DATA_WIDTH-1:SH]};
                OP_ROR:  data_o = {data_i[SH-1:0], data_i[DATA_WIDTH-1:SH]};
                OP_ROL:  data_o = {data_i[DATA_WIDTH-SH-1:0], data_i[DATA_WIDTH-1:DATA_WIDTH-SH]};
                default: data_o = data_i;
            endcase
        end else begin
            data_o = data_i;
        end
    end

endmodule

// File: rtl/pipelined_barrel_shifter.sv
// log2(DATA_WIDTH)-stage pipelined shifter with valid/ready at both ends and flush.
module pipelined_barrel_shifter
    import shifter_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic flush,
    pipelined_barrel_shifter_if.slave bus
);

    localparam int NS = ADDR_WIDTH;
    // op/sign/count are consumed by the following stage only, so the last stage has none.
    localparam int NP = ADDR_WIDTH - 1;

    logic [DATA_WIDTH-1:0] data_q [NS];
    logic [DATA_WIDTH-1:0] data_d [NS];
    logic [DATA_WIDTH-1:0] stage_out [NS];
    logic [NS-1:0]         valid_q, valid_d;
    logic [NS-1:0]         err_q, err_d;
    logic [OP_W-1:0]       op_q [NP];
    logic [OP_W-1:0]       op_d [NP];
    logic [ADDR_WIDTH-1:0] cnt_q [NP];
    logic [ADDR_WIDTH-1:0] cnt_d [NP];
    logic [NP-1:0]         sign_q, sign_d;
    logic                  stall;

    for (genvar k = 0; k < NS; k++) begin : g_stage
        logic [DATA_WIDTH-1:0] din;
        logic [OP_W-1:0]       opin;
        logic                  sgn;
        logic                  en;
        if (k == 0) begin : g_first
            assign din  = bus.data_in;
            assign opin = bus.op;
            assign sgn  = bus.data_in[DATA_WIDTH-1];
            assign en   = bus.shift_count[0];
        end else begin : g_rest
            assign din  = data_q[k-1];
            assign opin = op_q[k-1];
            assign sgn  = sign_q[k-1];
            assign en   = cnt_q[k-1][k];
        end
        shift_stage #(.DATA_WIDTH(DATA_WIDTH), .STAGE(k)) u_stage (
            .data_i (din),
            .op_i   (opin),
            .sign_i (sgn),
            .en_i   (en),
            .data_o (stage_out[k])
        );
    end

    // Next-state for every stage register: flush clears valids, stall holds everything.
    always_comb begin
        stall   = valid_q[NS-1] & ~bus.out_ready;
        data_d  = data_q;
        valid_d = valid_q;
        err_d   = err_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        sign_d  = sign_q;
        if (flush) begin
            valid_d = {NS{1'b0}};
        end else if (stall) begin
            valid_d = valid_q;
        end else begin
            valid_d[0] = bus.in_valid;
            data_d[0]  = stage_out[0];
            err_d[0]   = ~op_is_legal(bus.op);
            op_d[0]    = bus.op;
            cnt_d[0]   = bus.shift_count;
            sign_d[0]  = bus.data_in[DATA_WIDTH-1];
            for (int k = 1; k < NS; k++) begin
                valid_d[k] = valid_q[k-1];
                data_d[k]  = stage_out[k];
                err_d[k]   = err_q[k-1];
            end
            for (int k = 1; k < NP; k++) begin
                op_d[k]   = op_q[k-1];
                cnt_d[k]  = cnt_q[k-1];
                sign_d[k] = sign_q[k-1];
            end
        end
    end

    // Stage register bank with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= {NS{1'b0}};
            err_q   <= {NS{1'b0}};
            sign_q  <= {NP{1'b0}};
            for (int k = 0; k < NS; k++) begin
                data_q[k] <= {DATA_WIDTH{1'b0}};
            end
            for (int k = 0; k < NP; k++) begin
                op_q[k]  <= {OP_W{1'b0}};
                cnt_q[k] <= {ADDR_WIDTH{1'b0}};
            end
        end else begin
            valid_q <= valid_d;
            err_q   <= err_d;
            sign_q  <= sign_d;
            data_q  <= data_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.in_ready  = ~stall;
    assign bus.out_valid = valid_q[NS-1];
    assign bus.data_out  = data_q[NS-1];
    assign bus.out_err   = err_q[NS-1];

endmodule
